regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file with async clear, hardwired-zero register, same-cycle
//  write-to-read bypass and a per-register pending scoreboard. Sits in the decode/writeback
//  path of the core: decode reads operands and marks destinations pending; writeback writes
//  and clears pending. Successor to the plain 2R1W register file.
// PARAMETERS
//  NUM_REGS  32   number of architectural registers (need not be a power of two)
//  XLEN      32   register width in bits
//  AW        $clog2(NUM_REGS)   address width (derived; do not override)
//  ZERO_REG  1    1: register 0 reads 0, ignores writes, never pending
//  BYPASS    1    1: same-cycle write data forwarded to read ports
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  w_en      in   1      writeback enable
//  waddr     in   AW     writeback address
//  wdata     in   XLEN   writeback data
//  iss_en    in   1      issue: mark iss_addr pending
//  iss_addr  in   AW     destination register being issued
//  raddr1    in   AW     read address, port 1
//  raddr2    in   AW     read address, port 2
//  rdata1    out  XLEN   read data, port 1 (combinational)
//  rdata2    out  XLEN   read data, port 2 (combinational)
//  rbusy1    out  1      raddr1 has an outstanding producer
//  rbusy2    out  1      raddr2 has an outstanding producer
//  pend_cnt  out  $clog2(NUM_REGS+1)  number of registers currently pending
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers=0, all pending bits=0, pend_cnt=0; hence rdata*=0,
//    rbusy*=0 while held. Deassertion mid-stream: first edge after release acts normally.
//  - Write: at posedge, if w_en and waddr valid (waddr<NUM_REGS, and !=0 when ZERO_REG),
//    reg[waddr]<=wdata. Otherwise write dropped silently.
//  - Read: combinational, zero latency. Address >=NUM_REGS or (ZERO_REG & addr==0) -> 0.
//    BYPASS=1 and valid write this cycle to same addr -> rdata=wdata; else stored value.
//    BYPASS=0 -> stored value (new data visible the cycle after the write).
//  - Scoreboard, at posedge: w_en on valid waddr clears pending[waddr]; iss_en on valid
//    iss_addr sets pending[iss_addr]. Same address both: set wins (newer producer) -> stays 1.
//  - rbusyN = pending[raddrN] & ~(BYPASS & valid w_en & waddr==raddrN & ~(iss_en & iss_addr==raddrN)).
//    Invalid/zero address -> rbusyN=0.
//  - pend_cnt registered, equals popcount(pending) every cycle: +1 on set of a clear bit,
//    -1 on clear of a set bit, net 0 for set+clear of different bits or set of a set bit.
//    Never wraps (max NUM_REGS).
//  - w_en to a non-pending register is legal (writes data, pend_cnt unchanged).
// STRUCTURE
//  - regfile_pkg: default NUM_REGS/XLEN, function for address validity, localparam CW for
//    pend_cnt width.
//  - One sub-module: regfile_sb_pend (pending bit vector + pend_cnt + rbusy lookup); data
//    array, bypass muxes and zero handling stay in regfile_sb.
// TESTING
//  - Reset: write 0xDEADBEEF to r5, assert rst_n=0 between edges -> rdata1(r5)=0 immediately,
//    pend_cnt=0.
//  - Zero reg: w_en waddr=0 wdata=0x1234, iss_en iss_addr=0 -> rdata1(r0)=0, rbusy1=0,
//    pend_cnt=0.
//  - Bypass: w_en waddr=7 wdata=0xA5A5A5A5, raddr1=raddr2=7 same cycle -> rdata1=rdata2=0xA5A5A5A5;
//    rerun with BYPASS=0 -> old value that cycle, new value next.
//  - Scoreboard: iss r3 -> next cycle rbusy1(r3)=1, pend_cnt=1; w_en r3 -> rbusy1=0 same cycle
//    (BYPASS=1), pend_cnt=0 after edge.
//  - Simultaneous: r4 pending; iss_en r4 and w_en r4 same cycle -> r4 still pending, pend_cnt
//    unchanged; iss r9 + w_en r4 -> pend_cnt unchanged, r9 set, r4 clear.
//  - Depth: NUM_REGS=24, raddr1=30, w_en waddr=30 -> rdata1=0, no array write, pend_cnt unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_XLEN     = 32;
  localparam int unsigned CW           = $clog2(DEF_NUM_REGS + 1);

  // Address is usable when inside the array and not the hardwired-zero register.
  function automatic logic addr_valid(input int unsigned addr,
                                      input int unsigned num_regs,
                                      input logic        zero_reg);
    return (addr < num_regs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_sb_pend.sv
// Pending-producer bit vector, live pending count and per-port busy lookup.
module regfile_sb_pend
  import regfile_pkg::*;
#(
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned AW       = $clog2(NUM_REGS),
  localparam int unsigned PCW      = $clog2(NUM_REGS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_wr_vld,
  input  logic [AW-1:0]  i_waddr,
  input  logic           i_iss_vld,
  input  logic [AW-1:0]  i_iss_addr,
  input  logic           i_rd1_vld,
  input  logic [AW-1:0]  i_raddr1,
  input  logic           i_rd2_vld,
  input  logic [AW-1:0]  i_raddr2,
  output logic           o_rbusy1_c,
  output logic           o_rbusy2_c,
  output logic [PCW-1:0] o_pend_cnt
);

  localparam logic BYP = (BYPASS != 0);

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [PCW-1:0]      r_pend_cnt;
  logic                w_inc;
  logic                w_dec;
  logic                w_fwd1;
  logic                w_fwd2;

  // Next pending vector: writeback clears, issue sets; issue applied last so it wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_wr_vld)  w_pend_nxt[i_waddr]    = 1'b0;
    if (i_iss_vld) w_pend_nxt[i_iss_addr] = 1'b1;
  end

  // Count delta: only real 0->1 and 1->0 transitions move the count.
  always_comb begin
    w_inc = i_iss_vld & ~r_pend[i_iss_addr];
    w_dec = i_wr_vld & r_pend[i_waddr] & ~(i_iss_vld & (i_iss_addr == i_waddr));
  end

  // Pending state and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= r_pend_cnt + PCW'(w_inc) - PCW'(w_dec);
    end
  end

  // Busy lookup: a same-cycle writeback retires the producer unless it is re-issued.
  always_comb begin
    w_fwd1 = BYP & i_wr_vld & (i_waddr == i_raddr1) & ~(i_iss_vld & (i_iss_addr == i_raddr1));
    w_fwd2 = BYP & i_wr_vld & (i_waddr == i_raddr2) & ~(i_iss_vld & (i_iss_addr == i_raddr2));
    o_rbusy1_c = i_rd1_vld & r_pend[i_raddr1] & ~w_fwd1;
    o_rbusy2_c = i_rd2_vld & r_pend[i_raddr2] & ~w_fwd2;
  end

  assign o_pend_cnt = r_pend_cnt;

endmodule

// File: rtl/regfile_sb.sv
// 2R1W register file with hardwired zero, optional write bypass and pending scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter  int unsigned XLEN     = DEF_XLEN,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned AW       = $clog2(NUM_REGS),
  localparam int unsigned PCW      = $clog2(NUM_REGS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_en,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            rbusy1,
  output logic            rbusy2,
  output logic [PCW-1:0]  pend_cnt
);

  localparam logic ZR  = (ZERO_REG != 0);
  localparam logic BYP = (BYPASS != 0);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            w_wr_vld;
  logic            w_iss_vld;
  logic            w_rd1_vld;
  logic            w_rd2_vld;

  // Address qualification for every port.
  always_comb begin
    w_wr_vld  = w_en   & addr_valid(32'(waddr),    NUM_REGS, ZR);
    w_iss_vld = iss_en & addr_valid(32'(iss_addr), NUM_REGS, ZR);
    w_rd1_vld = addr_valid(32'(raddr1), NUM_REGS, ZR);
    w_rd2_vld = addr_valid(32'(raddr2), NUM_REGS, ZR);
  end

  // Data array; invalid or zero-register writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (w_wr_vld) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Read muxes: zero for unusable addresses, forwarded data on a same-cycle write.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (w_rd1_vld) begin
      if (BYP && w_wr_vld && (waddr == raddr1)) rdata1 = wdata;
      else                                      rdata1 = r_regs[raddr1];
    end
    if (w_rd2_vld) begin
      if (BYP && w_wr_vld && (waddr == raddr2)) rdata2 = wdata;
      else                                      rdata2 = r_regs[raddr2];
    end
  end

  regfile_sb_pend #(
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_pend (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_vld   (w_wr_vld),
    .i_waddr    (waddr),
    .i_iss_vld  (w_iss_vld),
    .i_iss_addr (iss_addr),
    .i_rd1_vld  (w_rd1_vld),
    .i_raddr1   (raddr1),
    .i_rd2_vld  (w_rd2_vld),
    .i_raddr2   (raddr2),
    .o_rbusy1_c (rbusy1),
    .o_rbusy2_c (rbusy2),
    .o_pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: three configurations share stimulus, each checked against its own model.
module tb_regfile_sb;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_en = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
  logic        rb1_a, rb2_a, rb1_b, rb2_b, rb1_c, rb2_c;
  logic [5:0]  pc_a, pc_b;
  logic [4:0]  pc_c;

  always #5 clk = ~clk;

  // a: defaults, b: no bypass, c: 24 registers
  regfile_sb #(.NUM_REGS(32), .XLEN(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_a), .rdata2(rd2_a), .rbusy1(rb1_a), .rbusy2(rb2_a), .pend_cnt(pc_a));
  regfile_sb #(.NUM_REGS(32), .XLEN(32), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_b), .rdata2(rd2_b), .rbusy1(rb1_b), .rbusy2(rb2_b), .pend_cnt(pc_b));
  regfile_sb #(.NUM_REGS(24), .XLEN(32), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_c), .rdata2(rd2_c), .rbusy1(rb1_c), .rbusy2(rb2_c), .pend_cnt(pc_c));

  typedef struct packed {
    logic [NI-1:0][31:0] rd1;
    logic [NI-1:0][31:0] rd2;
    logic [NI-1:0]       rb1;
    logic [NI-1:0]       rb2;
    logic [NI-1:0][5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          n_regs [NI] = '{32, 32, 24};
  bit          byp    [NI] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_reg  [NI][32];
  bit          m_pend [NI][32];

  function automatic bit m_valid(int k, int a);
    return (a < n_regs[k]) && (a != 0);
  endfunction

  function automatic bit m_fwd(int k, int a);
    return byp[k] && w_en && m_valid(k, int'(waddr)) && (int'(waddr) == a);
  endfunction

  function automatic logic [31:0] m_read(int k, int a);
    if (!m_valid(k, a)) return 32'h0;
    if (m_fwd(k, a))    return wdata;
    return m_reg[k][a];
  endfunction

  function automatic bit m_busy(int k, int a);
    if (!m_valid(k, a)) return 1'b0;
    return m_pend[k][a] && !(m_fwd(k, a) && !(iss_en && int'(iss_addr) == a));
  endfunction

  function automatic int m_count(int k);
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_pend[k][i]) c++;
    return c;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 32; i++) begin
        m_reg[k][i]  = 32'h0;
        m_pend[k][i] = 1'b0;
      end
  endtask

  // Apply one cycle of stimulus, queue expected outputs, then advance the model past the edge.
  task automatic step(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input bit ie, input logic [4:0] ia, input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    @(negedge clk);
    rst_n    = !rst;
    w_en     = rst ? 1'b0 : we;
    waddr    = wa;
    wdata    = wd;
    iss_en   = rst ? 1'b0 : ie;
    iss_addr = ia;
    raddr1   = r1;
    raddr2   = r2;
    if (rst) m_clear();
    #1;
    for (int k = 0; k < NI; k++) begin
      e.rd1[k] = m_read(k, int'(r1));
      e.rd2[k] = m_read(k, int'(r2));
      e.rb1[k] = m_busy(k, int'(r1));
      e.rb2[k] = m_busy(k, int'(r2));
      e.cnt[k] = 6'(m_count(k));
    end
    exp_q.push_back(e);
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        if (w_en && m_valid(k, int'(wa))) begin
          m_reg[k][wa]  = wd;
          m_pend[k][wa] = 1'b0;
        end
        if (iss_en && m_valid(k, int'(ia))) m_pend[k][ia] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Monitor: compare live DUT outputs with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdata1", 0, rd1_a, e.rd1[0]);
        chk("rdata2", 0, rd2_a, e.rd2[0]);
        chk("rbusy1", 0, 32'(rb1_a), 32'(e.rb1[0]));
        chk("rbusy2", 0, 32'(rb2_a), 32'(e.rb2[0]));
        chk("pend_cnt", 0, 32'(pc_a), 32'(e.cnt[0]));
        chk("rdata1", 1, rd1_b, e.rd1[1]);
        chk("rdata2", 1, rd2_b, e.rd2[1]);
        chk("rbusy1", 1, 32'(rb1_b), 32'(e.rb1[1]));
        chk("rbusy2", 1, 32'(rb2_b), 32'(e.rb2[1]));
        chk("pend_cnt", 1, 32'(pc_b), 32'(e.cnt[1]));
        chk("rdata1", 2, rd1_c, e.rd1[2]);
        chk("rdata2", 2, rd2_c, e.rd2[2]);
        chk("rbusy1", 2, 32'(rb1_c), 32'(e.rb1[2]));
        chk("rbusy2", 2, 32'(rb2_c), 32'(e.rb2[2]));
        chk("pend_cnt", 2, 32'(pc_c), 32'(e.cnt[2]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    m_clear();
    step(1, 0, 0, 0, 0, 0, 5, 0);
    step(1, 0, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    // reset wipes stored data immediately
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
    step(0, 0, 0, 0, 1, 6, 5, 6);
    step(1, 0, 0, 0, 0, 0, 5, 6);
    step(0, 0, 0, 0, 0, 0, 5, 6);
    // hardwired zero register
    step(0, 1, 0, 32'h1234, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // bypass vs. no-bypass
    step(0, 1, 7, 32'hA5A5A5A5, 0, 0, 7, 7);
    step(0, 0, 0, 0, 0, 0, 7, 7);
    // issue then writeback
    step(0, 0, 0, 0, 1, 3, 3, 0);
    step(0, 0, 0, 0, 0, 0, 3, 0);
    step(0, 1, 3, 32'h33, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0, 0, 3, 0);
    // simultaneous issue/writeback, same and different registers
    step(0, 0, 0, 0, 1, 4, 4, 0);
    step(0, 1, 4, 32'h44, 1, 4, 4, 0);
    step(0, 0, 0, 0, 0, 0, 4, 0);
    step(0, 1, 4, 32'h45, 1, 9, 4, 9);
    step(0, 0, 0, 0, 0, 0, 4, 9);
    // out-of-range address on the 24-entry instance
    step(0, 0, 0, 0, 1, 30, 30, 0);
    step(0, 1, 30, 32'hCAFEF00D, 0, 0, 30, 30);
    step(0, 0, 0, 0, 0, 0, 30, 23);
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(60, 0) == 0), $urandom_range(1, 0) == 1,
           5'($urandom_range(31, 0)), $urandom(),
           $urandom_range(1, 0) == 1, 5'($urandom_range(31, 0)),
           5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
    end
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
